// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory bus arbiter
package mem_arb_pkg;

  localparam int REQ_COUNT = 3;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } e_arb_state;

  typedef enum logic [1:0] {
    REQ_PI  = 2'd0,
    REQ_CPU = 2'd1,
    REQ_DMA = 2'd2
  } e_requester;

endpackage

// File: rtl/mem_arb_select.sv
// rtl/mem_arb_select.sv - combinational winner picker: PI priority, starvation limit, CPU/DMA round-robin
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic [REQ_COUNT-1:0] request,
  input  logic [7:0]           starve_cnt,
  input  logic                 rr_next,
  output logic [REQ_COUNT-1:0] winner,
  output logic                 pi_deferred
);

  logic others;
  logic pi_wins;

  // PI wins unless it has used up its run of grants while CPU/DMA wait
  always_comb begin
    winner      = '0;
    others      = request[REQ_CPU] | request[REQ_DMA];
    pi_wins     = request[REQ_PI] && ((starve_cnt < 8'(STARVE_LIMIT)) || !others);
    pi_deferred = request[REQ_PI] && !pi_wins;
    if (pi_wins) begin
      winner[REQ_PI] = 1'b1;
    end else if (request[REQ_CPU] && request[REQ_DMA]) begin
      if (rr_next) winner[REQ_DMA] = 1'b1;
      else         winner[REQ_CPU] = 1'b1;
    end else if (request[REQ_CPU]) begin
      winner[REQ_CPU] = 1'b1;
    end else if (request[REQ_DMA]) begin
      winner[REQ_DMA] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory bus among PI, CPU and DMA, one transaction per grant
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        pi_request,
  output logic        pi_ack,
  input  logic        pi_write,
  input  logic [31:0] pi_address,
  input  logic [15:0] pi_wdata,
  input  logic [1:0]  pi_wmask,
  output logic [15:0] pi_rdata,

  input  logic        cpu_request,
  output logic        cpu_ack,
  input  logic        cpu_write,
  input  logic [31:0] cpu_address,
  input  logic [15:0] cpu_wdata,
  input  logic [1:0]  cpu_wmask,
  output logic [15:0] cpu_rdata,

  input  logic        dma_request,
  output logic        dma_ack,
  input  logic        dma_write,
  input  logic [31:0] dma_address,
  input  logic [15:0] dma_wdata,
  input  logic [1:0]  dma_wmask,
  output logic [15:0] dma_rdata,

  output logic        mem_request,
  input  logic        mem_ack,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_wmask,
  input  logic [15:0] mem_rdata,

  output logic [2:0]  grant,
  output logic        pi_starved
);

  e_arb_state           state, state_next;
  logic [REQ_COUNT-1:0] grant_next;
  logic [REQ_COUNT-1:0] req_vec;
  logic [REQ_COUNT-1:0] winner;
  logic [7:0]           starve_cnt, starve_next;
  logic                 rr_next, rr_next_nxt;
  logic                 pi_starved_next;
  logic                 pi_deferred;
  logic                 owner_request;
  logic                 others;

  assign req_vec       = {dma_request, cpu_request, pi_request};
  assign others        = cpu_request | dma_request;
  assign owner_request = |(grant & req_vec);

  mem_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_select (
    .request    (req_vec),
    .starve_cnt (starve_cnt),
    .rr_next    (rr_next),
    .winner     (winner),
    .pi_deferred(pi_deferred)
  );

  // State, grant and fairness bookkeeping; reset drops any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      starve_cnt <= '0;
      rr_next    <= 1'b0;
      pi_starved <= 1'b0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      starve_cnt <= starve_next;
      rr_next    <= rr_next_nxt;
      pi_starved <= pi_starved_next;
    end
  end

  // Next state: arbitrate in IDLE, release on ack or when the owner aborts
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    starve_next     = starve_cnt;
    rr_next_nxt     = rr_next;
    pi_starved_next = 1'b0;
    case (state)
      ARB_IDLE: begin
        grant_next = '0;
        if (|winner) begin
          grant_next      = winner;
          state_next      = ARB_BUSY;
          pi_starved_next = pi_deferred;
          if (winner[REQ_PI]) begin
            if (!others)                             starve_next = '0;
            else if (starve_cnt < 8'(STARVE_LIMIT))  starve_next = starve_cnt + 8'd1;
          end else begin
            starve_next = '0;
            // Prefer the other one next time: CPU win -> DMA, DMA win -> CPU
            rr_next_nxt = winner[REQ_CPU];
          end
        end
      end
      ARB_BUSY: begin
        if (mem_ack || !owner_request) begin
          state_next = ARB_IDLE;
          grant_next = '0;
        end
      end
      default: begin
        state_next = ARB_IDLE;
        grant_next = '0;
      end
    endcase
  end

  // Downstream mux from the owner; zeros while idle so the bus stays quiet
  always_comb begin
    mem_request = owner_request;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    mem_wmask   = '0;
    if (grant[REQ_PI]) begin
      mem_write   = pi_write;
      mem_address = pi_address;
      mem_wdata   = pi_wdata;
      mem_wmask   = pi_wmask;
    end else if (grant[REQ_CPU]) begin
      mem_write   = cpu_write;
      mem_address = cpu_address;
      mem_wdata   = cpu_wdata;
      mem_wmask   = cpu_wmask;
    end else if (grant[REQ_DMA]) begin
      mem_write   = dma_write;
      mem_address = dma_address;
      mem_wdata   = dma_wdata;
      mem_wmask   = dma_wmask;
    end
  end

  // Ack goes only to the owner and is swallowed during reset; rdata is broadcast
  always_comb begin
    pi_ack    = mem_ack & grant[REQ_PI]  & ~reset;
    cpu_ack   = mem_ack & grant[REQ_CPU] & ~reset;
    dma_ack   = mem_ack & grant[REQ_DMA] & ~reset;
    pi_rdata  = mem_rdata;
    cpu_rdata = mem_rdata;
    dma_rdata = mem_rdata;
  end

endmodule
